fetch_sequencer: RTL and testbench

Program-counter sequencer for the 10-bit computer. Drives instr_rd_addr of the combinational instruction ROM, decodes control-flow opcodes (j, je, jal, ret, halt) and computes the next PC, keeping a small return-address stack for jal/ret. The current instruction is presented to the decode/datapath with a valid strobe. The datapath supplies the equal flag and a stall.

---
 rtl/fetch_sequencer.sv | 174 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer -- program-counter sequencer for the 10-bit computer.
//
// Drives the combinational instruction ROM address, decodes the control-flow
// opcodes (j, je, jal, ret, halt) and computes the next PC. A small
// return-address stack serves jal/ret. The current instruction goes to the
// decode/datapath along with a valid strobe.
//
// Optional build macro: SINGLE_STEP_EN
//   When defined, the block gains a 'step' input. RUN advances only on cycles
//   where step=1 and stall=0.
//
// Ports:
//   clk, rst         rising-edge clock; synchronous active-high reset
//   start            leaves IDLE for RUN (level or pulse; ignored elsewhere)
//   step             (SINGLE_STEP_EN only) advance enable
//   instr_rd_addr    ROM read address, always equal to the PC
//   instr            ROM data, combinational from instr_rd_addr
//   eq_flag          datapath equal flag, used by je
//   stall            datapath busy; hold the current instruction
//   instr_q          instruction to decode (pass-through of instr)
//   instr_valid      instr_q executes this cycle
//   halted           sequencer is in HALT
//   err              sticky stack fault (overflow or underflow)
//   dbg_state_o      FSM state (0 IDLE, 1 RUN, 2 HALT)
//
// Handshake: an instruction is consumed on a rising edge where instr_valid=1.
// instr_valid is combinational: (state==RUN) & ~stall (& step).
module fetch_sequencer #(
  parameter logic [9:0] RESET_PC  = 10'd0,
  parameter int         RAS_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic [9:0] instr_rd_addr,
  input  logic [9:0] instr,
  input  logic       eq_flag,
  input  logic       stall,
  output logic [9:0] instr_q,
  output logic       instr_valid,
  output logic       halted,
  output logic       err,
  output logic [1:0] dbg_state_o
);

  // sp counts occupied entries (0..RAS_DEPTH), so it needs one more code
  // than the entry index.
  localparam int SPW = $clog2(RAS_DEPTH + 1);
  localparam int AW  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [3:0] OP_J    = 4'b1100;
  localparam logic [3:0] OP_JE   = 4'b1101;
  localparam logic [3:0] OP_JAL  = 4'b1110;
  localparam logic [3:0] OP_RET  = 4'b0111;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [9:0]       ras_q [RAS_DEPTH];
  logic             halted_q;
  logic             err_q;

  logic             advance;
  logic             push_en;
  logic             fault;
  logic [3:0]       op;
  logic [9:0]       offset;
  logic [9:0]       pc_inc;
  logic [9:0]       pc_rel;
  logic [SPW-1:0]   sp_dec;
  logic             stack_full;
  logic             stack_empty;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    top_idx;

`ifdef SINGLE_STEP_EN
  assign advance = (state_q == S_RUN) && !stall && step;
`else
  assign advance = (state_q == S_RUN) && !stall;
`endif

  assign op     = instr[9:6];
  assign offset = {{4{instr[5]}}, instr[5:0]};
  // Both sums are 10 bits wide, so PC arithmetic wraps modulo 1024.
  assign pc_inc = pc_q + 10'd1;
  assign pc_rel = pc_q + offset;

  assign sp_dec      = sp_q - SPW'(1);
  assign stack_full  = (sp_q == SPW'(RAS_DEPTH));
  assign stack_empty = (sp_q == '0);
  // Index slices only reach the array when the matching full/empty guard
  // has already been checked.
  assign push_idx    = sp_q[AW-1:0];
  assign top_idx     = sp_dec[AW-1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    push_en = 1'b0;
    fault   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (advance) begin
          case (op)
            OP_J:  pc_d = pc_rel;
            OP_JE: pc_d = eq_flag ? pc_rel : pc_inc;
            OP_JAL: begin
              if (stack_full) begin
                fault   = 1'b1;
                state_d = S_HALT;
              end else begin
                push_en = 1'b1;
                sp_d    = sp_q + SPW'(1);
                pc_d    = pc_rel;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                fault   = 1'b1;
                state_d = S_HALT;
              end else begin
                sp_d = sp_dec;
                pc_d = ras_q[top_idx];
              end
            end
            OP_HALT: state_d = S_HALT;
            default: pc_d = pc_inc;
          endcase
        end
      end
      default: ; // HALT: only rst leaves
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      sp_q     <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      halted_q <= (state_d == S_HALT);
      err_q    <= err_q | fault;
      // Stack contents are deliberately not reset; only sp_q defines them.
      if (push_en) ras_q[push_idx] <= pc_inc;
    end
  end

  assign instr_rd_addr = pc_q;
  assign instr_q       = instr;
  assign instr_valid   = advance;
  assign halted        = halted_q;
  assign err           = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       step;
  logic [9:0] instr_rd_addr;
  logic [9:0] instr;
  logic       eq_flag;
  logic       stall;
  logic [9:0] instr_q;
  logic       instr_valid;
  logic       halted;
  logic       err;
  logic [1:0] dbg_state_o;

  logic [9:0] rom [1024];

  int n_checks = 0;
  int n_errors = 0;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM model
  assign instr = rom[instr_rd_addr];

  fetch_sequencer #(.RESET_PC(10'd0), .RAS_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
`ifdef SINGLE_STEP_EN
    .step          (step),
`endif
    .instr_rd_addr (instr_rd_addr),
    .instr         (instr),
    .eq_flag       (eq_flag),
    .stall         (stall),
    .instr_q       (instr_q),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .err           (err),
    .dbg_state_o   (dbg_state_o)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 10'd0;
  endtask

  task automatic run_from_reset();
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; eq_flag = 1'b0; step = 1'b1;
    clear_rom();

    // Reset state
    tick(); tick();
    chk("rst_addr", instr_rd_addr, 10'd0);
    chk("rst_valid", {9'd0, instr_valid}, 10'd0);
    chk("rst_halted", {9'd0, halted}, 10'd0);
    chk("rst_err", {9'd0, err}, 10'd0);
    chk("rst_state", {8'd0, dbg_state_o}, 10'd0);
    rst = 1'b0;
    tick();
    chk("idle_valid", {9'd0, instr_valid}, 10'd0);
    chk("idle_addr", instr_rd_addr, 10'd0);

    // Sequential fetch of non-flow opcodes 0..5
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("seq_valid0", {9'd0, instr_valid}, 10'd1);
    chk("seq_addr0", instr_rd_addr, 10'd0);
    chk("seq_q0", instr_q, rom[0]);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("seq_addr", instr_rd_addr, 10'(i));
      chk("seq_valid", {9'd0, instr_valid}, 10'd1);
    end

    // j forward/backward, negative wrap and 1023+1 wrap
    clear_rom();
    rom[0]    = {4'b1100, 6'd27};
    rom[27]   = {4'b1100, 6'h2f};        // -17
    rom[10]   = {4'b1100, 6'b110101};    // -11
    run_from_reset();
    chk("j_start", instr_rd_addr, 10'd0);
    tick(); chk("j_fwd", instr_rd_addr, 10'd27);
    tick(); chk("j_back", instr_rd_addr, 10'd10);
    tick(); chk("j_negwrap", instr_rd_addr, 10'd1023);
    tick(); chk("inc_wrap", instr_rd_addr, 10'd0);

    // je taken / not taken
    clear_rom();
    rom[0]  = {4'b1100, 6'd8};
    rom[8]  = {4'b1101, 6'd27};
    rom[35] = {4'b1100, 6'd37};          // -27 back to 8
    run_from_reset();
    tick(); chk("je_at8", instr_rd_addr, 10'd8);
    eq_flag = 1'b1;
    tick(); chk("je_taken", instr_rd_addr, 10'd35);
    tick(); chk("je_back8", instr_rd_addr, 10'd8);
    eq_flag = 1'b0;
    tick(); chk("je_nottaken", instr_rd_addr, 10'd9);

    // jal / ret
    clear_rom();
    rom[0]  = {4'b1100, 6'd17};
    rom[17] = {4'b1110, 6'd19};
    rom[39] = 10'b0111000000;
    run_from_reset();
    tick(); chk("jal_at17", instr_rd_addr, 10'd17);
    tick(); chk("jal_target", instr_rd_addr, 10'd36);
    tick(); tick(); tick();
    chk("ret_at39", instr_rd_addr, 10'd39);
    tick(); chk("ret_target", instr_rd_addr, 10'd18);
    chk("ret_noerr", {9'd0, err}, 10'd0);

    // Stack overflow on fifth nested jal
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = {4'b1110, 6'd1};
    run_from_reset();
    for (int i = 1; i <= 4; i++) tick();
    chk("ovf_at4", instr_rd_addr, 10'd4);
    chk("ovf_valid4", {9'd0, instr_valid}, 10'd1);
    chk("ovf_noerr_yet", {9'd0, err}, 10'd0);
    tick();
    chk("ovf_addr", instr_rd_addr, 10'd4);
    chk("ovf_err", {9'd0, err}, 10'd1);
    chk("ovf_halted", {9'd0, halted}, 10'd1);
    chk("ovf_valid", {9'd0, instr_valid}, 10'd0);
    chk("ovf_state", {8'd0, dbg_state_o}, 10'd2);
    tick();
    chk("ovf_hold", instr_rd_addr, 10'd4);

    // Underflow: ret right after reset
    clear_rom();
    rom[0] = 10'b0111000000;
    run_from_reset();
    chk("unf_err_cleared", {9'd0, err}, 10'd0);
    chk("unf_valid", {9'd0, instr_valid}, 10'd1);
    tick();
    chk("unf_err", {9'd0, err}, 10'd1);
    chk("unf_halted", {9'd0, halted}, 10'd1);
    chk("unf_addr", instr_rd_addr, 10'd0);

    // Stall at PC=12 over a jal: no push while stalled
    clear_rom();
    rom[0]  = {4'b1100, 6'd12};
    rom[12] = {4'b1110, 6'd1};
    rom[13] = 10'b0111000000;
    run_from_reset();
    tick(); chk("stall_at12", instr_rd_addr, 10'd12);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_valid", {9'd0, instr_valid}, 10'd0);
      tick();
      chk("stall_addr", instr_rd_addr, 10'd12);
    end
    stall = 1'b0;
    tick(); chk("stall_jal", instr_rd_addr, 10'd13);
    tick(); chk("stall_ret", instr_rd_addr, 10'd13);
    chk("stall_ret_noerr", {9'd0, err}, 10'd0);
    tick(); chk("stall_ret_empty", {9'd0, err}, 10'd1);
    chk("stall_ret_addr", instr_rd_addr, 10'd13);

    // halt at 35, start ignored, rst returns to IDLE
    clear_rom();
    rom[0]  = {4'b1100, 6'd31};
    rom[35] = 10'b1111000000;
    run_from_reset();
    tick(); tick(); tick(); tick(); tick();
    chk("halt_at35", instr_rd_addr, 10'd35);
    chk("halt_valid_once", {9'd0, instr_valid}, 10'd1);
    chk("halt_not_yet", {9'd0, halted}, 10'd0);
    tick();
    chk("halt_halted", {9'd0, halted}, 10'd1);
    chk("halt_valid", {9'd0, instr_valid}, 10'd0);
    chk("halt_addr", instr_rd_addr, 10'd35);
    chk("halt_err", {9'd0, err}, 10'd0);
    start = 1'b1;
    tick(); tick();
    chk("halt_start_ign", instr_rd_addr, 10'd35);
    chk("halt_start_state", {8'd0, dbg_state_o}, 10'd2);
    start = 1'b0;
    rst = 1'b1;
    tick();
    chk("halt_rst_addr", instr_rd_addr, 10'd0);
    chk("halt_rst_halted", {9'd0, halted}, 10'd0);
    chk("halt_rst_state", {8'd0, dbg_state_o}, 10'd0);
    rst = 1'b0;
    tick();
    chk("halt_rst_idle_valid", {9'd0, instr_valid}, 10'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
